// File: rtl/sram_dual_port_param.sv
// Simple dual-port SRAM: one byte-enabled write port, one read port, one clock.
// Post-reset sweep fills every word with INIT_VALUE before traffic is accepted.
module sram_dual_port_param #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter int                    WRITE_FIRST  = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                    Clk_In,
    input  logic                    Reset_In,
    input  logic                    Wr_En,
    input  logic [ADDR_WIDTH-1:0]   Wr_Addr,
    input  logic [DATA_WIDTH-1:0]   Wr_Data,
    input  logic [DATA_WIDTH/8-1:0] Wr_Byte_En,
    input  logic                    Rd_En,
    input  logic [ADDR_WIDTH-1:0]   Rd_Addr,
    output logic [DATA_WIDTH-1:0]   Rd_Data,
    output logic                    Rd_Valid,
    output logic                    Init_Busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  hit;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // The sweep shares the single write port with user writes.
    always_comb begin
        wr_fire  = Wr_En && (state == ST_READY);
        rd_fire  = Rd_En && (state == ST_READY);
        hit      = wr_fire && (Wr_Addr == Rd_Addr);
        mem_we   = wr_fire;
        mem_addr = Wr_Addr;
        mem_data = Wr_Data;
        mem_be   = Wr_Byte_En;
        if (state == ST_INIT) begin
            mem_we   = Reset_In;
            mem_addr = ptr;
            mem_data = INIT_VALUE;
            mem_be   = '1;
        end
    end

    always_ff @(posedge Clk_In) begin
        if (!Reset_In) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else if (state == ST_INIT) begin
            if (ptr == '1) begin
                state <= ST_READY;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_In) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_data[8*b +: 8];
                end
            end
        end
    end

    // Collision bypass: enabled bytes of a same-address write win.
    always_comb begin
        rd_word = mem[Rd_Addr];
        if ((WRITE_FIRST != 0) && hit) begin
            for (int b = 0; b < NB; b++) begin
                if (Wr_Byte_En[b]) begin
                    rd_word[8*b +: 8] = Wr_Data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clk_In) begin
        if (!Reset_In) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge Clk_In) begin
                if (!Reset_In) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign Rd_Valid = s2_valid;
            assign Rd_Data  = s2_data;
        end else begin : g_lat1
            assign Rd_Valid = s1_valid;
            assign Rd_Data  = s1_data;
        end
    endgenerate

    assign Init_Busy = (state == ST_INIT);

endmodule

// File: tb/tb_sram_dual_port_param.sv
// Bench for sram_dual_port_param: four instances (latency 1/2 x write/read-first)
// share one stimulus stream and are checked against an array-based model.
module tb_sram_dual_port_param;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    be;
    logic          re;
    logic [AW-1:0] ra;

    // 0: L1/WF1, 1: L1/WF0, 2: L2/WF1, 3: L2/WF0
    logic [DW-1:0] rd_data  [4];
    logic          rd_valid [4];
    logic          busy     [4];

    sram_dual_port_param #(.READ_LATENCY(1), .WRITE_FIRST(1)) u_l1w1 (
        .Clk_In(clk), .Reset_In(rst_n),
        .Wr_En(we), .Wr_Addr(wa), .Wr_Data(wd), .Wr_Byte_En(be),
        .Rd_En(re), .Rd_Addr(ra),
        .Rd_Data(rd_data[0]), .Rd_Valid(rd_valid[0]), .Init_Busy(busy[0])
    );
    sram_dual_port_param #(.READ_LATENCY(1), .WRITE_FIRST(0)) u_l1w0 (
        .Clk_In(clk), .Reset_In(rst_n),
        .Wr_En(we), .Wr_Addr(wa), .Wr_Data(wd), .Wr_Byte_En(be),
        .Rd_En(re), .Rd_Addr(ra),
        .Rd_Data(rd_data[1]), .Rd_Valid(rd_valid[1]), .Init_Busy(busy[1])
    );
    sram_dual_port_param #(.READ_LATENCY(2), .WRITE_FIRST(1)) u_l2w1 (
        .Clk_In(clk), .Reset_In(rst_n),
        .Wr_En(we), .Wr_Addr(wa), .Wr_Data(wd), .Wr_Byte_En(be),
        .Rd_En(re), .Rd_Addr(ra),
        .Rd_Data(rd_data[2]), .Rd_Valid(rd_valid[2]), .Init_Busy(busy[2])
    );
    sram_dual_port_param #(.READ_LATENCY(2), .WRITE_FIRST(0)) u_l2w0 (
        .Clk_In(clk), .Reset_In(rst_n),
        .Wr_En(we), .Wr_Addr(wa), .Wr_Data(wd), .Wr_Byte_En(be),
        .Rd_En(re), .Rd_Addr(ra),
        .Rd_Data(rd_data[3]), .Rd_Valid(rd_valid[3]), .Init_Busy(busy[3])
    );

    typedef struct {
        int            due;
        logic [DW-1:0] d_wf1;
        logic [DW-1:0] d_wf0;
    } rd_t;

    typedef struct {
        bit            we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [1:0]    be;
        bit            re;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp0;
    } vec_t;

    logic [DW-1:0] mem_m [DEPTH];
    bit            m_busy   = 1'b1;
    bit            rst_edge = 1'b0;
    int            sweep    = 0;
    int            cyc      = 0;
    rd_t           q1[$];
    rd_t           q2[$];
    int            total    = 0;
    int            bad      = 0;
    vec_t          tbl [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of one clock edge, evaluated on the inputs about to be sampled.
    task automatic model_edge();
        rst_edge = !rst_n;
        if (!rst_n) begin
            m_busy = 1'b1;
            sweep  = 0;
            q1.delete();
            q2.delete();
        end else if (m_busy) begin
            sweep++;
            if (sweep == DEPTH) begin
                m_busy = 1'b0;
                foreach (mem_m[i]) mem_m[i] = '0;
            end
        end else begin
            if (re) begin
                rd_t           e;
                logic [DW-1:0] nw;
                e.d_wf0 = mem_m[ra];
                nw      = e.d_wf0;
                if (we && wa == ra) begin
                    for (int b = 0; b < 2; b++)
                        if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
                end
                e.d_wf1 = nw;
                e.due   = cyc + 1;
                q1.push_back(e);
                e.due   = cyc + 2;
                q2.push_back(e);
            end
            if (we) begin
                for (int b = 0; b < 2; b++)
                    if (be[b]) mem_m[wa][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic check_outputs();
        rd_t e1;
        rd_t e2;
        rd_t e;
        bit  h1;
        bit  h2;
        bit  h;
        h1 = (q1.size() > 0) && (q1[0].due == cyc);
        h2 = (q2.size() > 0) && (q2[0].due == cyc);
        if (h1) e1 = q1.pop_front();
        if (h2) e2 = q2.pop_front();
        for (int k = 0; k < 4; k++) begin
            h = (k >= 2) ? h2 : h1;
            e = (k >= 2) ? e2 : e1;
            chk($sformatf("valid[%0d]", k), 32'(rd_valid[k]), 32'(h));
            if (h)
                chk($sformatf("data[%0d]", k), 32'(rd_data[k]),
                    32'((k % 2 == 0) ? e.d_wf1 : e.d_wf0));
            if (rst_edge)
                chk($sformatf("rst_data[%0d]", k), 32'(rd_data[k]), 32'h0);
            chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_busy));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle();
        we = 1'b0;
        re = 1'b0;
        be = 2'b00;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (busy[0]) n++;
            else break;
            tick();
        end
    endtask

    initial begin
        int n;

        // addr, data, byte-enable, read addr, expected WF1 / WF0 data
        tbl[0]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h00, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h7F, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'hFF, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h05, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b1, 8'h10, 16'hBEEF, 2'b11, 1'b0, 8'h00, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b1, 8'h10, 16'h1234, 2'b01, 1'b0, 8'h00, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h10, 16'hBE34, 16'hBE34};
        tbl[7]  = '{1'b1, 8'h20, 16'hAAAA, 2'b11, 1'b0, 8'h00, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b1, 8'h20, 16'h5555, 2'b10, 1'b1, 8'h20, 16'h55AA, 16'hAAAA};
        tbl[9]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h20, 16'h55AA, 16'h55AA};
        tbl[10] = '{1'b1, 8'h30, 16'h1111, 2'b00, 1'b0, 8'h00, 16'h0000, 16'h0000};
        tbl[11] = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h30, 16'h0000, 16'h0000};

        rst_n = 1'b0;
        wa    = '0;
        ra    = '0;
        wd    = '0;
        idle();
        #2;
        tick();
        tick();

        // Traffic during the sweep must be dropped.
        rst_n = 1'b1;
        we = 1'b1; wa = 8'h05; wd = 16'hFFFF; be = 2'b11;
        re = 1'b1; ra = 8'h05;
        count_busy(n);
        idle();
        chk("init_len", 32'(n), 32'd256);

        for (int i = 0; i < 12; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; be = tbl[i].be;
            re = tbl[i].re; ra = tbl[i].ra;
            tick();
            idle();
            if (tbl[i].re) begin
                chk($sformatf("vec%0d_l1_v", i), 32'(rd_valid[0] & rd_valid[1]), 32'd1);
                chk($sformatf("vec%0d_l1w1", i), 32'(rd_data[0]), 32'(tbl[i].exp1));
                chk($sformatf("vec%0d_l1w0", i), 32'(rd_data[1]), 32'(tbl[i].exp0));
                chk($sformatf("vec%0d_l2_early", i), 32'(rd_valid[2] | rd_valid[3]), 32'd0);
                tick();
                chk($sformatf("vec%0d_l2_v", i), 32'(rd_valid[2] & rd_valid[3]), 32'd1);
                chk($sformatf("vec%0d_l2w1", i), 32'(rd_data[2]), 32'(tbl[i].exp1));
                chk($sformatf("vec%0d_l2w0", i), 32'(rd_data[3]), 32'(tbl[i].exp0));
            end
        end
        tick();

        // Back-to-back reads, then a one-cycle reset flushes what is in flight.
        re = 1'b1; ra = 8'h10;
        tick();
        tick();
        tick();
        re    = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("flush_data_l2", 32'(rd_data[2]), 32'h0);
        rst_n = 1'b1;
        count_busy(n);
        chk("reinit_len", 32'(n), 32'd256);
        tick();
        chk("post_reinit_v", 32'(rd_valid[0] | rd_valid[2]), 32'd0);
        re = 1'b1; ra = 8'h10;
        tick();
        idle();
        chk("reinit_0x10_v", 32'(rd_valid[0]), 32'd1);
        chk("reinit_0x10_d", 32'(rd_data[0]), 32'h0);
        tick();
        tick();

        // Random traffic on a narrow address window for frequent collisions.
        for (int i = 0; i < 1000; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 3) != 0);
            be = 2'($urandom);
            wd = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wa = 8'($urandom);
                ra = 8'($urandom);
            end else begin
                wa = 8'($urandom_range(0, 7));
                ra = 8'($urandom_range(0, 7));
            end
            tick();
        end
        idle();
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_dual_port_param.md
Name: sram_dual_port_param

Overview:
- Parametrised simple dual-port SRAM: one write port and one independent read port on a single clock.
- Adds byte-enabled writes, configurable read latency (1 or 2), a selectable read/write collision policy, and a self-clearing initialisation sweep after reset.
- Next-generation general storage primitive for buffers and register-file style storage in the data-storage library.

Parameters:
- DATA_WIDTH, 16: word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 8: address width. DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1: cycles from an accepted read to Rd_Valid/Rd_Data. Legal values are 1 and 2.
- WRITE_FIRST, 1: same-address, same-cycle collision policy. 1 = read returns the newly written data. 0 = read returns the old data.
- INIT_VALUE, 0: DATA_WIDTH-bit value written to every word by the post-reset sweep.

Ports:
- Clk_In  input  1  clock, rising edge.
- Reset_In  input  1  synchronous, active-low reset.
- Wr_En  input  1  write request.
- Wr_Addr  input  ADDR_WIDTH  write address.
- Wr_Data  input  DATA_WIDTH  write data.
- Wr_Byte_En  input  DATA_WIDTH/8  per-byte write enable. Bit i covers Wr_Data[8i+7:8i].
- Rd_En  input  1  read request.
- Rd_Addr  input  ADDR_WIDTH  read address.
- Rd_Data  output  DATA_WIDTH  read data. Valid only while Rd_Valid=1.
- Rd_Valid  output  1  one-cycle pulse per accepted read.
- Init_Busy  output  1  high while reset is held and during the initialisation sweep.

Behaviour:
- Reset (Reset_In sampled 0 at a rising edge):
  - Outputs: Rd_Data=0, Rd_Valid=0, Init_Busy=1.
  - Read pipeline is flushed; in-flight reads never produce Rd_Valid.
  - FSM goes to INIT with sweep pointer = 0.
  - Memory contents are not cleared while Reset_In stays low.
- FSM has two states, INIT and READY.
  - INIT: each edge with Reset_In=1 writes INIT_VALUE to the pointer address and increments the pointer.
  - On the edge that writes DEPTH-1, the FSM goes to READY and Init_Busy falls.
  - Init_Busy is therefore high for exactly DEPTH cycles after reset release.
  - In INIT, Wr_En and Rd_En are ignored and dropped, not queued.
  - READY: the FSM stays in READY until reset.
- Reset asserted mid-sweep or mid-operation: the FSM returns to INIT and the sweep restarts from address 0.
- Write, READY state:
  - Wr_En=1 at an edge updates every byte whose Wr_Byte_En bit is 1; other bytes keep their value.
  - Wr_Byte_En=0 with Wr_En=1 is a legal no-op.
- Read, READY state:
  - Rd_En=1 at edge N makes Rd_Valid=1 and Rd_Data = word at edge N+READ_LATENCY.
  - With Rd_En=0, Rd_Valid=0 and Rd_Data holds its last value.
  - Full throughput: one read and one write per cycle. Back-to-back reads give back-to-back Rd_Valid.
- Collision (Wr_En=1 and Rd_En=1, Wr_Addr==Rd_Addr, same edge):
  - WRITE_FIRST=1: enabled bytes return Wr_Data, disabled bytes return the old contents.
  - WRITE_FIRST=0: all bytes return the old contents.
- A write to an address after a read has been accepted never alters that read's returned data.
- Address range is the full DEPTH, with no wrap or out-of-range case. The sweep pointer stops after DEPTH-1.
- Reads of never-written addresses after the sweep return INIT_VALUE.

Test Plan:
1. Defaults. Release reset, count cycles. -> Init_Busy=1 for exactly 256 cycles. Then read addr 0x00, 0x7F, 0xFF -> each returns 0x0000 with Rd_Valid exactly 1 cycle after Rd_En.
2. Write 0xBEEF to 0x10 with Wr_Byte_En=2'b11, then 0x1234 with Wr_Byte_En=2'b01. -> Read 0x10 returns 0xBE34. Repeat with READ_LATENCY=2 -> same data, Rd_Valid 2 cycles after Rd_En.
3. Address 0x20 holds 0xAAAA. Same edge: write 0x5555 with Wr_Byte_En=2'b10 and read 0x20. -> WRITE_FIRST=1 returns 0x55AA; WRITE_FIRST=0 returns 0xAAAA. Next read returns 0x55AA in both cases.
4. During INIT, assert Wr_En to 0x05 with 0xFFFF and Rd_En. -> No Rd_Valid. After the sweep, 0x05 reads 0x0000.
5. READ_LATENCY=2: issue reads on 3 consecutive cycles, then pull Reset_In low for 1 cycle while 2 reads are still in flight. -> No further Rd_Valid, Rd_Data=0. Init_Busy stays high for 1 reset cycle + 256 cycles, then previously written data reads INIT_VALUE.
6. Random mixed read/write traffic (1000 cycles) against a reference model. -> Every Rd_Valid matches the model, including collisions under both WRITE_FIRST settings.
